// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared load/write-back encodings and W-stage record for the MIPS core
package mips_pkg;

  localparam int GPR_AW = 5;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [1:0]        a_lo;
    logic [31:0]       alu_out;
    logic [31:0]       rd;
    logic [2:0]        ld_type;
    logic [1:0]        wd_sel;
    logic [GPR_AW-1:0] wa;
    logic              we;
  } w_stage_t;

endpackage

// File: rtl/w_load_ext.sv
// rtl/w_load_ext.sv - byte/half selection and sign/zero extension of a loaded word
module w_load_ext
  import mips_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_ld_type,
  output logic [31:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd[7:0];
    case (i_offset)
      2'd1:    w_byte = i_rd[15:8];
      2'd2:    w_byte = i_rd[23:16];
      2'd3:    w_byte = i_rd[31:24];
      default: w_byte = i_rd[7:0];
    endcase
  end

  // Misaligned halves trap upstream, so only offset bit 1 picks the half.
  assign w_half = i_offset[1] ? i_rd[31:16] : i_rd[15:0];

  always_comb begin
    o_ext = i_rd;
    case (i_ld_type)
      LD_B:    o_ext = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_ext = {24'd0, w_byte};
      LD_H:    o_ext = {{16{w_half[15]}}, w_half};
      LD_HU:   o_ext = {16'd0, w_half};
      default: o_ext = i_rd;
    endcase
  end

endmodule

// File: rtl/mw_stage_reg.sv
// rtl/mw_stage_reg.sv - M/W pipeline register with load extension, write-back select and retire counter
// MW_TRACE_EN: when defined, prints a commit line for every nonzero-GPR write-back.
module mw_stage_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              M_stall,
  input  logic              M_flush,
  input  logic              M_valid,
  input  logic [31:0]       M_PC,
  input  logic [31:0]       M_A,
  input  logic [31:0]       M_ALUout,
  input  logic [31:0]       M_RD,
  input  logic [2:0]        M_ld_type,
  input  logic [1:0]        M_wd_sel,
  input  logic [GPR_AW-1:0] M_wa,
  input  logic              M_we,
  output logic              W_valid,
  output logic [31:0]       W_PC,
  output logic [GPR_AW-1:0] W_wa,
  output logic              W_we,
  output logic [31:0]       W_wd,
  output logic              W_fwd_we,
  output logic [31:0]       W_retire_cnt
);

  w_stage_t    r_w;
  logic [31:0] r_retire_cnt;
  logic [31:0] w_ld_ext;
  logic        w_unused_a_hi;

  assign w_unused_a_hi = ^M_A[31:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w          <= '0;
      r_retire_cnt <= '0;
    end else begin
      // The instruction sitting in W retires whenever W advances, flush included.
      if (r_w.valid && !M_stall) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (M_flush) begin
        r_w <= '0;
      end else if (!M_stall) begin
        r_w <= '{valid:   M_valid,
                 pc:      M_PC,
                 a_lo:    M_A[1:0],
                 alu_out: M_ALUout,
                 rd:      M_RD,
                 ld_type: M_ld_type,
                 wd_sel:  M_wd_sel,
                 wa:      M_wa,
                 we:      M_we};
      end
    end
  end

  w_load_ext u_load_ext (
    .i_rd      (r_w.rd),
    .i_offset  (r_w.a_lo),
    .i_ld_type (r_w.ld_type),
    .o_ext     (w_ld_ext)
  );

  always_comb begin
    W_wd = 32'd0;
    case (r_w.wd_sel)
      WD_ALU:  W_wd = r_w.alu_out;
      WD_MEM:  W_wd = w_ld_ext;
      WD_PC8:  W_wd = r_w.pc + 32'd8;
      default: W_wd = 32'd0;
    endcase
  end

  assign W_valid      = r_w.valid;
  assign W_PC         = r_w.pc;
  assign W_wa         = r_w.wa;
  assign W_we         = r_w.we & r_w.valid;
  assign W_fwd_we     = W_we & (r_w.wa != '0);
  assign W_retire_cnt = r_retire_cnt;

`ifdef MW_TRACE_EN
  always @(posedge clk) begin
    if (!reset && W_we && (W_wa != '0)) begin
      $display("%d@%h: $%d <= %h", $time, W_PC, W_wa, W_wd);
    end
  end
`else
`endif

endmodule

// File: doc/mw_stage_reg.md
# mw_stage_reg

Pipeline register between the M stage (data memory) and the W stage (register-file write-back) of the five-stage MIPS core. It captures the memory read word, ALU result, PC and destination info on each clock, then extends loads (lb/lbu/lh/lhu/lw) and selects the write-back data. It also provides a forwarding-qualified write port and a retired-instruction counter. Stall holds the register, flush inserts a bubble, and reset clears everything.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- M_stall  in  1  hold current W contents.
- M_flush  in  1  load a bubble into W (exception/interrupt at M).
- M_valid  in  1  M holds a real instruction.
- M_PC  in  32  PC of M instruction.
- M_A  in  32  memory/ALU address (byte offset from [1:0]).
- M_ALUout  in  32  ALU result.
- M_RD  in  32  word read from data memory.
- M_ld_type  in  3  load kind (package encoding).
- M_wd_sel  in  2  write-back source select.
- M_wa  in  5  destination GPR.
- M_we  in  1  GPR write request.
- W_valid  out  1  W holds a real instruction.
- W_PC  out  32  PC of W instruction.
- W_wa  out  5  destination GPR.
- W_we  out  1  GPR write enable (= stored we & W_valid).
- W_wd  out  32  write-back data.
- W_fwd_we  out  1  W_we & (W_wa != 0), for hazard forwarding.
- W_retire_cnt  out  32  count of instructions retired from W.

## Operation
- Stored fields: valid, PC, A[1:0], ALUout, RD, ld_type, wd_sel, wa, we.
- Update priority on posedge:
  - reset: all fields 0.
  - else M_flush: valid=0, we=0, PC=0, other fields 0.
  - else M_stall: hold.
  - else: capture all M_* inputs.
- Load extension is combinational on stored RD and A[1:0]:
  - LW=0: word.
  - LB=1: byte A[1:0], sign-extended.
  - LBU=2: byte, zero-extended.
  - LH=3: half A[1], sign-extended.
  - LHU=4: half, zero-extended.
  - Codes 5–7 behave as LW.
  - Alignment errors are trapped upstream, so A[0] is ignored for halves.
- W_wd by wd_sel:
  - ALU=0: ALUout.
  - MEM=1: extended load.
  - PC8=2: PC+8 (32-bit wrap).
  - 3: 0.
- W_retire_cnt increments by 1 on each non-reset posedge where W_valid=1 and M_stall=0. It wraps 0xFFFFFFFF→0.

## Timing
- Latency 1 cycle from M inputs to W outputs.
- W_wd, W_we and W_fwd_we are combinational from registered state only. There is no input-to-output combinational path.
- All outputs are 0 after reset, including W_retire_cnt.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stall: clears on that edge.
- M_valid=0 captured: W_we=0 regardless of M_we.

## Configuration
- Macro MW_TRACE_EN.
  - Defined: on each posedge with reset=0, W_we=1 and W_wa≠0, print "%d@%h: $%d <= %h" with $time, W_PC, W_wa, W_wd. This is the write-back commit trace for grading comparison.
  - Undefined: no display statements are compiled.
  - Functional behaviour is identical either way.

## Structure
- Shared package mips_pkg holds:
  - LD_* codes (3-bit).
  - WD_* select codes (2-bit).
  - The GPR address width.
- Sub-module w_load_ext (combinational; inputs: RD, offset, ld_type; output: extended word) is instantiated once inside.

## Test plan
- Reset: assert reset 1 cycle with all inputs nonzero -> every output 0 next cycle, retire_cnt=0.
- Loads: RD=0x8091A2F3, ld_type=LB, A=0x...3, wd_sel=MEM, wa=5, we=1 -> W_wd=0xFFFFFF80.
  - Same with LBU -> 0x00000080.
  - LH with A[1]=0 -> 0xFFFFA2F3.
  - LHU with A[1]=1 -> 0x00008091.
- PC8/fwd: M_PC=0x00003000, wd_sel=PC8, wa=31 -> W_wd=0x00003008, W_fwd_we=1.
  - wa=0 -> W_we=1, W_fwd_we=0, no trace line.
- Stall/flush: capture instr A, then M_stall=1 for 2 cycles with new M inputs -> W unchanged and retire_cnt unchanged.
  - M_stall=1 with M_flush=1 -> W_valid=0, W_we=0.
- Counter wrap: force 2 valid retirements from count 0xFFFFFFFF -> 0x00000000, then 0x00000001.
- Trace: with MW_TRACE_EN, PC=0x3004, wa=8, ALUout=0x1234 -> one line "@00003004: $ 8 <= 00001234". With the macro undefined, no output.
